// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the data RAM arbiter.
// Optional build macro: RAM_ARBITER_ROUND_ROBIN_EN (see arb_pick).
package ram_arbiter_pkg;

    localparam int NUM_PORTS = 2;

    // Lock owner: nobody, the core path (port 0) or the loader/debug master (port 1).
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    // Bits needed to hold a lock count in the range 0..lock_max.
    function automatic int lock_cnt_width(input int lock_max);
        return $clog2(lock_max + 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational two-way picker for the RAM arbiter.
// Build macro RAM_ARBITER_ROUND_ROBIN_EN: when defined, contention in the
// unlocked state goes to the port that did not win last; otherwise port 0
// always wins. A locked owner is the only candidate in both builds.
module arb_pick
    import ram_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid_i,
    input  owner_t               owner_i,
    input  logic                 last_i,
    output logic [NUM_PORTS-1:0] grant_o
);

`ifndef RAM_ARBITER_ROUND_ROBIN_EN
    // Fixed priority ignores the history bit.
    logic unused_last;
    assign unused_last = last_i;
`endif

    // Pick at most one valid port, honouring a current lock owner.
    always_comb begin
        grant_o = '0;
        case (owner_i)
            OWN_P0: grant_o[0] = valid_i[0];
            OWN_P1: grant_o[1] = valid_i[1];
            default: begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
                if (valid_i[0] && valid_i[1]) begin
                    grant_o = last_i ? 2'b01 : 2'b10;
                end else if (valid_i[0]) begin
                    grant_o = 2'b01;
                end else if (valid_i[1]) begin
                    grant_o = 2'b10;
                end
`else
                if (valid_i[0]) begin
                    grant_o = 2'b01;
                end else if (valid_i[1]) begin
                    grant_o = 2'b10;
                end
`endif
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Data RAM arbiter: port 0 is the core load/store path, port 1 the
// firmware loader/debug master. Grants one beat per cycle, returns read
// data one cycle later on the winning port and stalls the core while
// port 0 waits. Locked bursts are capped at LOCK_MAX consecutive grants.
// Arbitration policy is selected by RAM_ARBITER_ROUND_ROBIN_EN (in arb_pick).
//
// Handshake: a beat on port i transfers in the cycle where req_valid[i] and
// req_ready[i] are both 1. req_ready is combinational from this cycle's
// requests and may be 1 for at most one port. Requesters need not hold a
// request after it transfers; an unaccepted request may change freely.
// rsp_valid[i] is asserted for exactly one cycle, the cycle after a read
// beat on port i transferred; there is no response back-pressure.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int RAM_WIDTH  = 31,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 8
) (
    input  logic                            clk,
    input  logic                            a_reset_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS-1:0]            req_lock,
    input  logic [NUM_PORTS*RAM_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [RAM_WIDTH-1:0]            ram_address,
    output logic                            ram_we,
    output logic [DATA_WIDTH-1:0]           ram_wdata,
    input  logic [DATA_WIDTH-1:0]           ram_rdata,
    output logic                            core_stall,
    output logic [1:0]                      dbg_owner
);

    localparam int              CNT_W   = lock_cnt_width(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    owner_t               owner_q, owner_d;
    logic [CNT_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic                 last_q, last_d;
    logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;

    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] accept;
    logic                 own_idx;
    logic                 own_valid;
    logic                 own_lock;
    logic [CNT_W-1:0]     cnt_inc;

    arb_pick u_pick (
        .valid_i (req_valid),
        .owner_i (owner_q),
        .last_i  (last_q),
        .grant_o (grant)
    );

    // Nothing is granted while reset is asserted, even though requests may be present.
    assign req_ready  = grant & {NUM_PORTS{a_reset_n}};
    assign accept     = req_valid & req_ready;
    assign core_stall = req_valid[0] & ~req_ready[0];
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = ram_rdata;
    assign dbg_owner  = owner_q;

    assign own_idx   = (owner_q == OWN_P1);
    assign own_valid = req_valid[own_idx];
    assign own_lock  = req_lock[own_idx];
    assign cnt_inc   = lock_cnt_q + CNT_ONE;

    // Steer the granted port onto the RAM; drive zeros when idle.
    always_comb begin
        ram_address = '0;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        if (req_ready[0]) begin
            ram_address = req_addr[0 +: RAM_WIDTH];
            ram_we      = req_we[0];
            ram_wdata   = req_wdata[0 +: DATA_WIDTH];
        end else if (req_ready[1]) begin
            ram_address = req_addr[RAM_WIDTH +: RAM_WIDTH];
            ram_we      = req_we[1];
            ram_wdata   = req_wdata[DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Lock state machine, grant history and read-response tracking.
    always_comb begin
        owner_d     = owner_q;
        lock_cnt_d  = lock_cnt_q;
        last_d      = last_q;
        rsp_valid_d = accept & ~req_we;

        if (|accept) begin
            last_d = accept[1];
        end

        case (owner_q)
            OWN_P0, OWN_P1: begin
                // lock_cnt_q counts beats already granted; cnt_inc includes this one.
                // An idle owner, a dropped lock or a full burst all release.
                if (!own_valid || !own_lock || (cnt_inc >= CNT_MAX)) begin
                    owner_d    = OWN_NONE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = cnt_inc;
                end
            end
            default: begin
                owner_d    = OWN_NONE;
                lock_cnt_d = '0;
                // A single-beat cap means a lock can never extend past this beat.
                if ((|(accept & req_lock)) && (CNT_ONE < CNT_MAX)) begin
                    owner_d    = accept[1] ? OWN_P1 : OWN_P0;
                    lock_cnt_d = CNT_ONE;
                end
            end
        endcase
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            owner_q     <= OWN_NONE;
            lock_cnt_q  <= '0;
            last_q      <= 1'b1;
            rsp_valid_q <= '0;
        end else begin
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
// Honours RAM_ARBITER_ROUND_ROBIN_EN for the contention expectations.
module tb_ram_arbiter;

    localparam int AW = 31;
    localparam int DW = 32;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            a_reset_n = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [1:0]      req_we = '0;
    logic [1:0]      req_lock = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   ram_address;
    logic            ram_we;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata = '0;
    logic            core_stall;
    logic [1:0]      dbg_owner;

    logic [DW-1:0]   mem [0:255];
    logic [DW-1:0]   exp_q [$];
    int              n_checks = 0;
    int              n_errors = 0;

    ram_arbiter #(.RAM_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(8)) dut (
        .clk         (clk),
        .a_reset_n   (a_reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .ram_address (ram_address),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .core_stall  (core_stall),
        .dbg_owner   (dbg_owner)
    );

    // ---------------- clock / RAM model ----------------
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        if (a < 4)                    return DW'(32'h100 + a);
        if (a == 16)                  return 32'h0000_000A;
        if (a == 32)                  return 32'h0000_000B;
        if (a >= 64 && a < 80)        return DW'(32'h200 + (a - 64));
        return '0;
    endfunction

    always @(posedge clk) begin
        if (!a_reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else begin
            if (ram_we) mem[ram_address[7:0]] <= ram_wdata;
            ram_rdata <= mem[ram_address[7:0]];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_port(input int p, input logic v, input logic we, input logic lk,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_valid[p]          = v;
        req_we[p]             = we;
        req_lock[p]           = lk;
        req_addr[p*AW +: AW]  = addr;
        req_wdata[p*DW +: DW] = wd;
    endtask

    task automatic idle_all();
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Check one cycle's handshake outputs, then advance to the next negedge.
    task automatic cyc(input string tag, input logic [1:0] e_ready,
                       input logic [1:0] e_rsp, input logic e_stall);
        #1;
        check({tag, "_ready"}, req_ready, e_ready);
        check({tag, "_rsp_valid"}, rsp_valid, e_rsp);
        check({tag, "_stall"}, core_stall, e_stall);
        if (rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) check({tag, "_rsp_unexpected"}, 1, 0);
            else check({tag, "_rdata"}, rsp_rdata, exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with both ports requesting; port 0 asks for a write.
        set_port(0, 1'b1, 1'b1, 1'b0, 31'h10, 32'h55);
        set_port(1, 1'b1, 1'b0, 1'b0, 31'h20, '0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_address", ram_address, '0);
        check("rst_owner", dbg_owner, 2'd0);
        @(negedge clk);

        // Simultaneous reads at 0x10 / 0x20 right after release.
        a_reset_n = 1'b1;
        set_port(0, 1'b1, 1'b0, 1'b0, 31'h10, '0);
        #1;
        check("sim0_ram_address", ram_address, 31'h10);
        exp_q.push_back(32'hA);
        cyc("sim0", 2'b01, 2'b00, 1'b0);
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        check("sim1_ram_address", ram_address, 31'h20);
        exp_q.push_back(32'hB);
        cyc("sim1", 2'b10, 2'b01, 1'b0);
        idle_all();
        cyc("sim2", 2'b00, 2'b10, 1'b0);

        // Write then read the same address back to back.
        set_port(0, 1'b1, 1'b1, 1'b0, 31'h5, 32'hDEADBEEF);
        #1;
        check("wr_ram_we", ram_we, 1'b1);
        check("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
        check("wr_ram_address", ram_address, 31'h5);
        cyc("wr", 2'b01, 2'b00, 1'b0);
        set_port(0, 1'b1, 1'b0, 1'b0, 31'h5, '0);
        exp_q.push_back(32'hDEADBEEF);
        cyc("rd", 2'b01, 2'b00, 1'b0);
        idle_all();
        cyc("rd_rsp", 2'b00, 2'b01, 1'b0);

        // Port 1 locked reads at 0..3 while port 0 waits; port 1 then goes idle.
        set_port(1, 1'b1, 1'b0, 1'b1, 31'h0, '0);
        exp_q.push_back(32'h100);
        cyc("lk0", 2'b10, 2'b00, 1'b0);
        for (int c = 1; c < 4; c++) begin
            set_port(1, 1'b1, 1'b0, 1'b1, AW'(c), '0);
            set_port(0, 1'b1, 1'b0, 1'b0, 31'h10, '0);
            exp_q.push_back(DW'(32'h100 + c));
            if (c == 1) begin
                #1;
                check("lk1_owner", dbg_owner, 2'd2);
            end
            cyc($sformatf("lk%0d", c), 2'b10, 2'b10, 1'b1);
        end
        set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc("lk4", 2'b00, 2'b10, 1'b1);
        exp_q.push_back(32'hA);
        cyc("lk5", 2'b01, 2'b00, 1'b0);
        idle_all();
        cyc("lk6", 2'b00, 2'b01, 1'b0);

        // Lock cap: port 1 keeps req_lock high for 12 beats, port 0 waits from cycle 1.
        for (int c = 0; c < 12; c++) begin
            logic [1:0] e_ready;
            logic [1:0] e_rsp;
            set_port(1, 1'b1, 1'b0, 1'b1, AW'(64 + c), '0);
            if (c >= 1 && c <= 8) set_port(0, 1'b1, 1'b0, 1'b0, 31'h20, '0);
            else                  set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
            e_ready = (c == 8) ? 2'b01 : 2'b10;
            e_rsp   = (c == 0) ? 2'b00 : (c == 9) ? 2'b01 : 2'b10;
            if (c == 8) exp_q.push_back(32'hB);
            else        exp_q.push_back(DW'(32'h200 + c));
            cyc($sformatf("lim%0d", c), e_ready, e_rsp, (c >= 1 && c <= 7));
        end
        idle_all();
        cyc("lim_drain", 2'b00, 2'b10, 1'b0);
        #1;
        check("lim_owner_release", dbg_owner, 2'd0);
        @(negedge clk);

        // Reset in the cycle after a locked read was accepted.
        set_port(0, 1'b1, 1'b0, 1'b1, 31'h10, '0);
        cyc("mr0", 2'b01, 2'b00, 1'b0);
        idle_all();
        #1;
        check("mr_inflight_rsp", rsp_valid, 2'b01);
        check("mr_inflight_owner", dbg_owner, 2'd1);
        a_reset_n = 1'b0;
        #1;
        check("mr_rsp_cleared", rsp_valid, 2'b00);
        check("mr_owner_cleared", dbg_owner, 2'd0);
        @(negedge clk);
        #1;
        check("mr_rsp_held", rsp_valid, 2'b00);
        @(negedge clk);
        a_reset_n = 1'b1;

        // Sustained contention: fixed priority starves port 1, round robin alternates.
        for (int c = 0; c < 4; c++) begin
            logic [1:0] e_ready;
            logic [1:0] e_rsp;
            set_port(0, 1'b1, 1'b0, 1'b0, 31'h10, '0);
            set_port(1, 1'b1, 1'b0, 1'b0, 31'h20, '0);
            e_ready = (RR && (c % 2 == 1)) ? 2'b10 : 2'b01;
            e_rsp   = (c == 0) ? 2'b00 : (RR && (c % 2 == 0)) ? 2'b10 : 2'b01;
            exp_q.push_back((e_ready == 2'b01) ? 32'hA : 32'hB);
            cyc($sformatf("cont%0d", c), e_ready, e_rsp, e_ready[1]);
        end
        idle_all();
        cyc("cont_drain", 2'b00, RR ? 2'b10 : 2'b01, 1'b0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single data RAM between two requesters: port 0 is the core load/store path from the ALU, and port 1 is a firmware loader/debug master.
- Each cycle it grants at most one valid/ready request to the RAM, returns read data one cycle later on the winning port, and raises a core stall while port 0 is blocked.
- Locked sequences (burst loads) are supported, bounded by a lock-length counter so neither port starves.

Parameters:
- RAM_WIDTH, 31, RAM address width in bits.
- DATA_WIDTH, 32, data word width in bits.
- LOCK_MAX, 8, maximum consecutive grants to one locked owner before a forced release; must be >= 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- a_reset_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-port request valid; bit i belongs to port i.
- req_ready  output  2  per-port accept; one-hot or zero.
- req_we  input  2  per-port write enable; 1 = write, 0 = read.
- req_lock  input  2  per-port request to keep the grant after this beat.
- req_addr  input  2*RAM_WIDTH  per-port address; port i is in slice [i*RAM_WIDTH +: RAM_WIDTH].
- req_wdata  input  2*DATA_WIDTH  per-port write data, packed the same way.
- rsp_valid  output  2  per-port read response valid.
- rsp_rdata  output  DATA_WIDTH  read data; valid only when a rsp_valid bit is set.
- ram_address  output  RAM_WIDTH  RAM address.
- ram_we  output  1  RAM write strobe.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_rdata  input  DATA_WIDTH  RAM synchronous read data, valid one cycle after the address.
- core_stall  output  1  req_valid[0] & ~req_ready[0]; freezes the program counter.

Behaviour:
- Reset values: owner = NONE, lock_cnt = 0, last = 1, and every registered output is 0. The RAM outputs are 0 while no port is granted.
- Grant is combinational in the request cycle:
  - winner = arb(req_valid, owner, last);
  - req_ready = onehot(winner);
  - the ram_* outputs mux the winner's address, write enable and data;
  - ram_we = winner's req_we.
- A beat is accepted when req_valid[i] & req_ready[i]. Inputs are not held after acceptance.
- Lock state machine:
  - NONE: arbitrate normally. On accepting a beat with req_lock[i] = 1, go to LOCKED(i) with lock_cnt = 1.
  - LOCKED(i): only port i can be granted; the other port's ready is 0.
    - Accepted beat with req_lock[i] = 1 and lock_cnt < LOCK_MAX: lock_cnt increments.
    - Accepted beat with req_lock[i] = 0, or lock_cnt == LOCK_MAX: go to NONE.
    - req_valid[i] = 0 for one cycle: go to NONE immediately. Idle owners release; no grant is issued that cycle.
  - After a forced release at LOCK_MAX, the next cycle arbitrates normally, and the other port wins if it is valid.
- Fixed priority (default build): port 0 beats port 1 when both are valid in NONE.
- last records the most recently granted port, updated on every accepted beat.
- Read response:
  - A read accepted in cycle N gives rsp_valid[i] = 1 in cycle N+1 and rsp_rdata = ram_rdata, passed through combinationally from the RAM's registered output.
  - Writes never produce a response.
- Back-to-back reads from either port sustain one per cycle, with responses in acceptance order.
- Write then read of the same address in consecutive cycles returns the new data; this relies on the RAM's write-then-read ordering.
- Reset mid-operation: owner, lock_cnt and rsp_valid clear immediately, and an in-flight read response is dropped.

Optional Feature:
- Macro: RAM_ARBITER_ROUND_ROBIN_EN.
- Defined: in NONE, when both ports are valid, the port other than last wins.
- Undefined: fixed priority to port 0.
- The lock behaviour is identical in both builds.

Decomposition:
- Shared package ram_arbiter_pkg holds:
  - typedef enum {OWN_NONE, OWN_P0, OWN_P1} owner_t;
  - localparam NUM_PORTS = 2;
  - a function for the lock-count width, $clog2(LOCK_MAX+1).
- One natural sub-module, arb_pick: a combinational two-way picker with inputs valid, owner and last and a one-hot grant output. It holds the only ifdef for the optional feature.

Test Plan:
- Reset: hold a_reset_n = 0 with both ports valid -> req_ready = 0, rsp_valid = 0, ram_we = 0. After release, port 0 is granted the same cycle.
- Simultaneous access: both ports valid for reads at 0x10 and 0x20, RAM preloaded with 0xA/0xB.
  - Fixed build: P0 is ready in cycle 0, rsp_valid = 01 with 0xA in cycle 1, P1 is granted in cycle 1, rsp_valid = 10 with 0xB in cycle 2; core_stall = 0 throughout.
  - Round-robin build: alternates grants across repeated contention.
- Lock: P1 locked reads at 0..3 with P0 valid -> P0 ready = 0 and core_stall = 1 for 4 cycles; P0 is granted on the cycle after P1 drops req_lock.
- Lock limit (LOCK_MAX = 8): P1 holds req_lock = 1 for 12 beats -> exactly 8 consecutive P1 grants, then P0 is granted.
- Write followed by read: P0 writes 0xDEADBEEF to 0x5, then reads 0x5 next cycle -> rsp_rdata = 0xDEADBEEF, and no rsp_valid for the write.
- Mid-operation reset: assert a_reset_n low in the cycle after a read is accepted -> rsp_valid stays 0 and the owner returns to NONE.
